// File: rtl/io_host_bridge.sv
//==============================================================================
// Module      : io_host_bridge
// Description : Host-to-CPU byte bridge.
//               - Input path: each accepted host byte is presented on
//                 Cpu_Data_input and followed by a timed Enter press/release
//                 sequence.
//               - Output path: every change on the CPU data output bus is
//                 captured into a small FIFO that the host drains.
//               Optional feature macro: IO_HOST_BRIDGE_OVERFLOW_EN adds a
//               sticky Overflow flag for captures lost to a full FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module io_host_bridge #(
    parameter int ENTER_CYCLES = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       In_valid,
    input  logic [7:0] In_data,
    output logic       In_ready,
    output logic [7:0] Cpu_Data_input,
    output logic       Cpu_Enter,
    input  logic [7:0] Cpu_Data_output,
    input  logic       Cpu_Halt,
    output logic       Out_valid,
    output logic [7:0] Out_data,
    input  logic       Out_ready,
    output logic       Overflow,
    output logic       Halted
);

    localparam int               c_AW         = $clog2(FIFO_DEPTH);
    localparam logic [3:0]       c_ENTER_LAST = 4'(ENTER_CYCLES - 1);
    localparam logic [c_AW:0]    c_FULL       = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]    c_CNT_ONE    = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0]  c_PTR_ONE    = c_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_enter_cnt;
    logic [7:0]      r_cpu_data;
    logic            r_halted;
    logic            w_accept;
    logic            w_in_ready;
    logic            w_enter;

    logic [7:0]      r_prev;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_wr;

    //--------------------------------------------------------------------------
    // Input path
    //--------------------------------------------------------------------------

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and Moore outputs; In_ready is masked while Reset is held
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_enter      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = !r_halted && !Reset;
                w_accept   = In_valid && w_in_ready;
                if (w_accept) begin
                    w_state_next = S_PRESS;
                end
            end
            S_PRESS: begin
                w_enter = 1'b1;
                if (r_enter_cnt == c_ENTER_LAST) begin
                    w_state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Press-length counter and latched CPU input byte
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_enter_cnt <= 4'd0;
            r_cpu_data  <= 8'h00;
        end else if (w_accept) begin
            r_enter_cnt <= 4'd0;
            r_cpu_data  <= In_data;
        end else if (r_state == S_PRESS) begin
            r_enter_cnt <= r_enter_cnt + 4'd1;
        end
    end

    // One-cycle registered copy of the CPU halt status
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= Cpu_Halt;
        end
    end

    assign In_ready       = w_in_ready;
    assign Cpu_Enter      = w_enter;
    assign Cpu_Data_input = r_cpu_data;
    assign Halted         = r_halted;

    //--------------------------------------------------------------------------
    // Output capture path
    //--------------------------------------------------------------------------

    assign w_push = (Cpu_Data_output != r_prev);
    assign w_full = (r_count == c_FULL);
    assign w_pop  = (r_count != '0) && Out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_wr   = w_push && (!w_full || w_pop);

    // Previous-value register used for change detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_prev <= 8'h00;
        end else begin
            r_prev <= Cpu_Data_output;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge Clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= Cpu_Data_output;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign Out_valid = (r_count != '0);
    assign Out_data  = Out_valid ? r_mem[r_rd_ptr] : 8'h00;

`ifdef IO_HOST_BRIDGE_OVERFLOW_EN
    logic w_drop;
    logic r_overflow;

    assign w_drop = w_push && w_full && !w_pop;

    // Sticky record of any capture lost to a full FIFO
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign Overflow = r_overflow;
`else
    assign Overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/io_host_bridge.md
IO_HOST_BRIDGE -- requirements
Module: io_host_bridge

Interface
REQ-001 Parameter ENTER_CYCLES, default 2, number of consecutive cycles Cpu_Enter is held high per input byte (legal range 1..15).
REQ-002 Parameter FIFO_DEPTH, default 4, number of entries in the output capture FIFO (power of two, 2..16).
REQ-003 Clk  input  1  single clock; all logic on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 In_valid  input  1  host offers a byte for the CPU.
REQ-006 In_data  input  8  host byte.
REQ-007 In_ready  output  1  bridge accepts In_data this cycle.
REQ-008 Cpu_Data_input  output  8  byte presented to the CPU data input.
REQ-009 Cpu_Enter  output  1  Enter strobe to the CPU control unit.
REQ-010 Cpu_Data_output  input  8  CPU data output bus.
REQ-011 Cpu_Halt  input  1  CPU halted.
REQ-012 Out_valid  output  1  FIFO non-empty; Out_data is valid.
REQ-013 Out_data  output  8  FIFO head entry; 0x00 when empty.
REQ-014 Out_ready  input  1  host consumes the head entry when Out_valid is high.
REQ-015 Overflow  output  1  sticky lost-capture flag.
REQ-016 Halted  output  1  Cpu_Halt registered by one cycle.

Function
REQ-017 Input FSM states: IDLE, PRESS, RELEASE.
REQ-018 IDLE: In_ready = !Halted; In_valid && In_ready -> Cpu_Data_input <= In_data, go to PRESS.
REQ-019 PRESS: Cpu_Enter = 1 for exactly ENTER_CYCLES cycles (internal counter), then go to RELEASE.
REQ-020 RELEASE: Cpu_Enter = 0 for exactly one cycle, then go to IDLE.
REQ-021 In_ready = 0 in PRESS and RELEASE; In_ready is low for ENTER_CYCLES+1 cycles after each accept.
REQ-022 Cpu_Data_input holds its value until the next accepted byte.
REQ-023 Halted rising during PRESS or RELEASE: sequence completes normally; In_ready stays 0 while Halted = 1.
REQ-024 Capture: a prev register samples Cpu_Data_output every cycle; Cpu_Data_output != prev -> push Cpu_Data_output in that same cycle.
REQ-025 Out_valid rises the cycle after the first push into an empty FIFO.
REQ-026 Pop when Out_valid && Out_ready; Out_data advances to the next entry in the following cycle.
REQ-027 Push while full with no pop -> value dropped, FIFO contents unchanged.
REQ-028 Push while full with a simultaneous pop -> both occur, count unchanged, no drop.
REQ-029 Read and write pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.

Reset
REQ-030 During Reset: FSM = IDLE, Cpu_Enter = 0, Cpu_Data_input = 0x00, In_ready = 0.
REQ-031 During Reset: FIFO emptied, Out_valid = 0, Out_data = 0x00, prev = 0x00, Overflow = 0, Halted = 0.
REQ-032 Reset asserted mid-PRESS drops Cpu_Enter on the next edge; no partial sequence resumes afterwards.
REQ-033 In_ready = 1 in the first cycle after Reset deasserts, provided Cpu_Halt = 0.

Configuration
REQ-034 Macro IO_HOST_BRIDGE_OVERFLOW_EN defined: Overflow sets on any dropped push and stays set until Reset.
REQ-035 Macro IO_HOST_BRIDGE_OVERFLOW_EN undefined: Overflow is tied to 0, no sticky register exists, and drop behaviour is unchanged.

Verification
REQ-036 After reset, In_data=0x5A with In_valid for 1 cycle -> Cpu_Data_input=0x5A next cycle, Cpu_Enter high exactly 2 cycles then low, In_ready low 3 cycles.
REQ-037 Cpu_Data_output 0x00->0x11->0x11->0x22 with Out_ready=0 -> FIFO holds 0x11 then 0x22, Out_valid=1 one cycle after 0x11 appears.
REQ-038 Five distinct changes 0x01..0x05 with Out_ready=0 -> 0x01..0x04 stored, 0x05 dropped, Overflow=1 with macro defined, 0 without.
REQ-039 FIFO full, new change 0x77 together with Out_ready=1 -> head popped, 0x77 stored, count stays 4, Overflow stays 0.
REQ-040 Cpu_Halt=1 in the first PRESS cycle -> Cpu_Enter still high 2 cycles, In_ready=0 until Cpu_Halt=0 plus one cycle.
REQ-041 Reset asserted in the second PRESS cycle -> Cpu_Enter=0 and Out_valid=0 on the next edge, In_ready=1 one cycle after Reset deasserts.
